// File: rtl/nmea_rmc_parser.sv
`default_nettype none
// ============================================================================
// Module      : nmea_rmc_parser
// Description : Byte-serial NMEA-0183 $GPRMC parser. Locates RMC sentences
//               in the GPS byte stream and verifies their XOR checksum. On a
//               good sentence it publishes UTC hh:mm:ss and the fix status.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               gps_valid_in        - gps_data_in carries a byte this cycle
//               gps_data_in[7:0]    - ASCII byte from the GPS UART
//               utc_hour/min/sec    - last committed UTC time
//               fix_valid           - last committed status (1='A', 0='V')
//               time_strobe         - 1-cycle pulse when the outputs update
//               sentence_err        - 1-cycle pulse on a rejected sentence
// Revision    : 1.0 - initial release
// ============================================================================
module nmea_rmc_parser #(
    parameter int MAX_LEN     = 82,
    parameter bit CHECK_CKSUM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gps_valid_in,
    input  logic [7:0] gps_data_in,
    output logic [4:0] utc_hour,
    output logic [5:0] utc_min,
    output logic [5:0] utc_sec,
    output logic       fix_valid,
    output logic       time_strobe,
    output logic       sentence_err
);
    localparam int c_len_w = $clog2(MAX_LEN + 2);
    localparam logic [c_len_w-1:0] c_max_len = c_len_w'(MAX_LEN);

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_hdr    = 4'd1;
    localparam logic [3:0] c_st_time   = 4'd2;
    localparam logic [3:0] c_st_tfrac  = 4'd3;
    localparam logic [3:0] c_st_stat   = 4'd4;
    localparam logic [3:0] c_st_scomma = 4'd5;
    localparam logic [3:0] c_st_skip   = 4'd6;
    localparam logic [3:0] c_st_ck1    = 4'd7;
    localparam logic [3:0] c_st_ck2    = 4'd8;

    logic [3:0]         r_state, w_state_next;
    logic [2:0]         r_idx;
    logic [c_len_w-1:0] r_len;
    logic [7:0]         r_cksum;
    logic [23:0]        r_time_sh;   // hh mm ss as six BCD digits, oldest in MSBs
    logic               r_stat_sh;
    logic [3:0]         r_ck_hi;
    logic [4:0]         r_hour;
    logic [5:0]         r_min, r_sec;
    logic               r_fix, r_strobe, r_err;

    logic               w_dollar, w_is_digit, w_is_hex, w_overlen, w_ck_ok, w_range_bad;
    logic [3:0]         w_hex_val;
    logic [7:0]         w_hdr_char;
    logic [c_len_w-1:0] w_len_inc;
    logic [6:0]         w_hh, w_mm, w_ss;
    logic               w_restart, w_err, w_commit, w_xor_en;

    // Two BCD digits to binary: tens*10 built as tens*8 + tens*2.
    function automatic logic [6:0] dec2(input logic [3:0] tens, input logic [3:0] ones);
        return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
    endfunction

    assign w_dollar   = (gps_data_in == 8'h24);
    assign w_is_digit = (gps_data_in >= 8'h30) && (gps_data_in <= 8'h39);
    assign w_is_hex   = w_is_digit
                      || ((gps_data_in >= 8'h41) && (gps_data_in <= 8'h46))
                      || ((gps_data_in >= 8'h61) && (gps_data_in <= 8'h66));
    // 'A'..'F' and 'a'..'f' both have low nibble 1..6, so +9 gives 10..15.
    assign w_hex_val  = w_is_digit ? gps_data_in[3:0] : gps_data_in[3:0] + 4'd9;
    assign w_len_inc  = r_len + c_len_w'(1);
    assign w_overlen  = (w_len_inc > c_max_len);
    assign w_hh       = dec2(r_time_sh[23:20], r_time_sh[19:16]);
    assign w_mm       = dec2(r_time_sh[15:12], r_time_sh[11:8]);
    assign w_ss       = dec2(r_time_sh[7:4],   r_time_sh[3:0]);
    assign w_range_bad = (w_hh > 7'd23) || (w_mm > 7'd59) || (w_ss > 7'd59);
    assign w_ck_ok    = !CHECK_CKSUM || ({r_ck_hi, w_hex_val} == r_cksum);

    always_comb begin
        case (r_idx)
            3'd0:    w_hdr_char = "G";
            3'd1:    w_hdr_char = "P";
            3'd2:    w_hdr_char = "R";
            3'd3:    w_hdr_char = "M";
            3'd4:    w_hdr_char = "C";
            default: w_hdr_char = ",";
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (gps_valid_in) begin
            if (w_dollar) begin
                w_state_next = c_st_hdr;
            end else if (w_err || w_commit) begin
                w_state_next = c_st_idle;
            end else begin
                case (r_state)
                    c_st_hdr: begin
                        if (gps_data_in != w_hdr_char) w_state_next = c_st_idle;
                        else if (r_idx == 3'd5)        w_state_next = c_st_time;
                    end
                    c_st_time: begin
                        if (r_idx == 3'd6)
                            w_state_next = (gps_data_in == ",") ? c_st_stat : c_st_tfrac;
                    end
                    c_st_tfrac:  if (gps_data_in == ",") w_state_next = c_st_stat;
                    c_st_stat:   w_state_next = c_st_scomma;
                    c_st_scomma: w_state_next = c_st_skip;
                    c_st_skip:   if (gps_data_in == "*") w_state_next = c_st_ck1;
                    c_st_ck1:    w_state_next = c_st_ck2;
                    default:     w_state_next = r_state;
                endcase
            end
        end
    end

    // Per-byte actions and sentence verdicts
    always_comb begin
        w_restart = 1'b0;
        w_err     = 1'b0;
        w_commit  = 1'b0;
        w_xor_en  = 1'b0;
        if (gps_valid_in) begin
            if (w_dollar) begin
                w_restart = 1'b1;
            end else if (r_state != c_st_idle) begin
                w_xor_en = (r_state == c_st_hdr) || (r_state == c_st_time)
                        || (r_state == c_st_tfrac) || (r_state == c_st_stat)
                        || (r_state == c_st_scomma)
                        || ((r_state == c_st_skip) && (gps_data_in != "*"));
                if (w_overlen) begin
                    w_err = 1'b1;
                end else begin
                    case (r_state)
                        c_st_time: begin
                            if (r_idx < 3'd6) w_err = !w_is_digit;
                            else              w_err = (gps_data_in != ",") && (gps_data_in != ".");
                        end
                        c_st_stat:   w_err = (gps_data_in != "A") && (gps_data_in != "V");
                        c_st_scomma: w_err = (gps_data_in != ",");
                        c_st_ck1:    w_err = !w_is_hex;
                        c_st_ck2: begin
                            if (!w_is_hex || !w_ck_ok || w_range_bad) w_err    = 1'b1;
                            else                                      w_commit = 1'b1;
                        end
                        default: w_err = 1'b0;
                    endcase
                end
            end
        end
    end

    // Datapath: length, checksum, shadow fields and published outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= 3'd0;
            r_len     <= '0;
            r_cksum   <= 8'd0;
            r_time_sh <= 24'd0;
            r_stat_sh <= 1'b0;
            r_ck_hi   <= 4'd0;
            r_hour    <= 5'd0;
            r_min     <= 6'd0;
            r_sec     <= 6'd0;
            r_fix     <= 1'b0;
            r_strobe  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_strobe <= w_commit;
            r_err    <= w_err;
            if (w_restart) begin
                r_len   <= c_len_w'(1);
                r_cksum <= 8'd0;
                r_idx   <= 3'd0;
            end else if (gps_valid_in && (r_state != c_st_idle)) begin
                r_len <= w_len_inc;
                if (w_xor_en) r_cksum <= r_cksum ^ gps_data_in;
                case (r_state)
                    c_st_hdr: r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                    c_st_time: begin
                        if (r_idx < 3'd6) begin
                            r_time_sh <= {r_time_sh[19:0], gps_data_in[3:0]};
                            r_idx     <= r_idx + 3'd1;
                        end
                    end
                    c_st_stat: r_stat_sh <= (gps_data_in == "A");
                    c_st_ck1:  r_ck_hi   <= w_hex_val;
                    default:   r_idx     <= r_idx;
                endcase
            end
            if (w_commit) begin
                r_hour <= w_hh[4:0];
                r_min  <= w_mm[5:0];
                r_sec  <= w_ss[5:0];
                r_fix  <= r_stat_sh;
            end
        end
    end

    assign utc_hour     = r_hour;
    assign utc_min      = r_min;
    assign utc_sec      = r_sec;
    assign fix_valid    = r_fix;
    assign time_strobe  = r_strobe;
    assign sentence_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nmea_rmc_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmea_rmc_parser
// Description : Self-checking bench for nmea_rmc_parser. Directed sentences
//               push their expected commit/error event into a queue; a
//               monitor pops and compares on every strobe or error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmea_rmc_parser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gps_valid_in = 1'b0;
    logic [7:0] gps_data_in = 8'h00;
    logic [4:0] utc_hour;
    logic [5:0] utc_min, utc_sec;
    logic       fix_valid, time_strobe, sentence_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       f;
    } exp_t;
    exp_t exp_q[$];

    // Last-good model of the published outputs
    logic [4:0] m_h = 5'd0;
    logic [5:0] m_m = 6'd0, m_s = 6'd0;
    logic       m_f = 1'b0;

    nmea_rmc_parser #(.MAX_LEN(82), .CHECK_CKSUM(1'b1)) dut (
        .clk(clk), .rst(rst),
        .gps_valid_in(gps_valid_in), .gps_data_in(gps_data_in),
        .utc_hour(utc_hour), .utc_min(utc_min), .utc_sec(utc_sec),
        .fix_valid(fix_valid), .time_strobe(time_strobe), .sentence_err(sentence_err)
    );

    always #5 clk = ~clk;

    function automatic byte hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return byte'({4'h3, n});
        return byte'((lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10);
    endfunction

    // "$" + body + "*" + checksum computed over body
    function automatic string mk(input string body, input bit lower);
        byte   cs = 8'h00;
        string t  = "  ";
        for (int i = 0; i < body.len(); i++) cs ^= body[i];
        t[0] = hexc(cs[7:4], lower);
        t[1] = hexc(cs[3:0], lower);
        return {"$", body, "*", t};
    endfunction

    task automatic exp_commit(input int h, input int m, input int s, input bit f);
        exp_t e;
        m_h = 5'(h); m_m = 6'(m); m_s = 6'(s); m_f = f;
        e.is_err = 1'b0; e.h = m_h; e.m = m_m; e.s = m_s; e.f = m_f;
        exp_q.push_back(e);
    endtask

    task automatic exp_error();
        exp_t e;
        e.is_err = 1'b1; e.h = m_h; e.m = m_m; e.s = m_s; e.f = m_f;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input byte b);
        @(negedge clk);
        gps_valid_in = 1'b1;
        gps_data_in  = b;
        @(posedge clk);
        #1;
        gps_valid_in = 1'b0;
    endtask

    // gap=1 inserts one idle cycle between consecutive bytes
    task automatic send_str(input string s, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gap && (i < s.len() - 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_crlf();
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (utc_hour !== 5'd0 || utc_min !== 6'd0 || utc_sec !== 6'd0 || fix_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_outputs got=%0d:%0d:%0d fix=%0b want=0:0:0 fix=0",
                     tag, utc_hour, utc_min, utc_sec, fix_valid);
        end
        check_bit({tag, "_strobe"}, time_strobe, 1'b0);
        check_bit({tag, "_err"}, sentence_err, 1'b0);
    endtask

    // Monitor: every pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && (time_strobe || sentence_err)) begin
            checks++;
            if (time_strobe && sentence_err) begin
                errors++;
                $display("FAIL both_pulses strobe=%0b err=%0b want exactly one", time_strobe, sentence_err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse strobe=%0b err=%0b time=%0d:%0d:%0d want no pulse",
                         time_strobe, sentence_err, utc_hour, utc_min, utc_sec);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sentence_err !== e.is_err || utc_hour !== e.h || utc_min !== e.m
                    || utc_sec !== e.s || fix_valid !== e.f) begin
                    errors++;
                    $display("FAIL event got err=%0b %0d:%0d:%0d fix=%0b want err=%0b %0d:%0d:%0d fix=%0b",
                             sentence_err, utc_hour, utc_min, utc_sec, fix_valid,
                             e.is_err, e.h, e.m, e.s, e.f);
                end
            end
        end
    end

    initial begin
        string s1, s1_bad, s_fill;

        s1     = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A";
        s1_bad = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6B";

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("reset");

        // 1: reference sentence commits; strobe right after the last byte
        exp_commit(12, 35, 19, 1'b1);
        send_str(s1, 1'b0);
        check_bit("t1_strobe_timing", time_strobe, 1'b1);
        send_crlf();

        // 2: wrong checksum -> error, outputs hold
        exp_error();
        send_str(s1_bad, 1'b0);
        send_crlf();

        // 3: GGA ignored silently, following RMC commits
        send_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47", 1'b0);
        send_crlf();
        exp_commit(12, 35, 19, 1'b1);
        send_str(s1, 1'b0);
        send_crlf();

        // 4: truncated sentence abandoned by '$'; fractional seconds skipped
        send_str("$GPRMC,2359", 1'b0);
        exp_commit(0, 0, 1, 1'b0);
        send_str(mk("GPRMC,000001.00,V,,,,,,,,,N", 1'b0), 1'b0);
        send_crlf();

        // 5: gps_valid_in toggling every other cycle
        exp_commit(12, 35, 19, 1'b1);
        send_str(s1, 1'b1);
        check_bit("t5_strobe_timing", time_strobe, 1'b1);
        send_crlf();

        // 6: reset in the middle of SKIP, then replay
        send_str(s1.substr(0, 29), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_h = 5'd0; m_m = 6'd0; m_s = 6'd0; m_f = 1'b0;
        check_outputs_zero("midreset");
        exp_commit(12, 35, 19, 1'b1);
        send_str(s1, 1'b0);
        send_crlf();

        // Upper range boundary with lowercase checksum digits
        exp_commit(23, 59, 59, 1'b1);
        send_str(mk("GPRMC,235959,A,,", 1'b1), 1'b0);

        // Out-of-range hour and minute
        exp_error();
        send_str(mk("GPRMC,240000,A,,", 1'b0), 1'b0);
        exp_error();
        send_str(mk("GPRMC,126000,A,,", 1'b0), 1'b0);

        // Non-digit in time, bad status, non-hex checksum
        exp_error();
        send_str(mk("GPRMC,12a519,A,,", 1'b0), 1'b0);
        exp_error();
        send_str(mk("GPRMC,123519,X,,", 1'b0), 1'b0);
        exp_error();
        send_str("$GPRMC,010203,A,*Z0", 1'b0);

        // Length boundary: 82 chars commits, 83 chars errors
        s_fill = "";
        for (int i = 0; i < 63; i++) s_fill = {s_fill, "x"};
        exp_commit(1, 2, 3, 1'b1);
        send_str(mk({"GPRMC,010203,A,", s_fill}, 1'b0), 1'b0);
        exp_error();
        send_str(mk({"GPRMC,040506,V,", s_fill, "x"}, 1'b0), 1'b0);
        send_crlf();

        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d pending want=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
